// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, in-order imem requests with credit
// control, response FIFO toward decode, and redirect flushing of stale fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  // state | meaning
  // IDLE  | first cycle after reset, no requests
  // FETCH | normal streaming, every response is kept
  // FLUSH | discarding drop_cnt responses from before a redirect
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  state_t state, state_nx;

  logic [31:0]   req_pc, rsp_pc, redirect_tgt;
  logic [CW-1:0] outstanding, drop_cnt, drop_cnt_nx, drop_after, fifo_count;
  logic [CW:0]   credit_used;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic          req_fire, push, pop, fifo_empty, fifo_full, credit_ok;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok    = credit_used < DEPTH_W;
  assign fifo_empty   = (fifo_count == '0);
  assign fifo_full    = (fifo_count == DEPTH_C);

  assign imem_req_valid = rst_n & (state != IDLE) & ~redirect_valid & credit_ok;
  assign imem_req_addr  = req_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Response arriving in the redirect cycle belongs to the old stream.
  assign drop_after = outstanding - CW'(imem_rsp_valid);
  assign push       = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);

  assign instr_valid    = rst_n & ~fifo_empty;
  assign pop            = instr_valid & instr_ready;
  assign instr          = fifo_data[rd_ptr];
  assign instr_pc       = fifo_pc[rd_ptr];
  assign instr_pc_plus4 = fifo_pc[rd_ptr] + 32'd4;

  always_comb begin
    drop_cnt_nx = drop_cnt;
    if (redirect_valid)
      drop_cnt_nx = drop_after;
    else if (imem_rsp_valid && drop_cnt != '0)
      drop_cnt_nx = drop_cnt - 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = FETCH;
      FETCH,
      FLUSH:       state_nx = (drop_cnt_nx != '0) ? FLUSH : FETCH;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_pc      <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nx;
      drop_cnt    <= drop_cnt_nx;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        req_pc <= redirect_tgt;
        rsp_pc <= redirect_tgt;
      end else begin
        if (req_fire) req_pc <= req_pc + 32'd4;
        if (push)     rsp_pc <= rsp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));
  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    (outstanding <= DEPTH_C) && (drop_cnt <= outstanding));

endmodule
